// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary sequencer: state encoding and default sizing.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int          N_DIGITS_DEF  = 3;
  localparam int          BIN_W_DEF     = 10;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_bin_seq_digit_adj.sv
// Reverse double-dabble digit correction: a nibble of 8 or more after the right shift loses 3.
module bcd_digit_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = i_nib[3] ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcd_bin_seq.sv
// Sequential packed-BCD to binary converter using BIN_W reverse double-dabble steps.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CHECK | one cycle: reject any captured digit above 9
// SHIFT | BIN_W shift/adjust steps on the working register
// DONE  | two cycles: result settles, then the one-cycle valid pulse
module bcd_bin_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int BIN_W    = BIN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic                  busy,
  output logic                  valid,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int WW    = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WW-1:0]      r_work;
  logic [CW-1:0]      r_cnt;
  logic               r_done_ph;
  logic               r_busy;
  logic               r_valid;
  logic [BIN_W-1:0]   r_bin;
  logic               r_err;

  logic [WW-1:0]      w_shift;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [WW-1:0]      w_work_nxt;
  logic               w_bad;
  logic               w_last;

  assign w_shift    = r_work >> 1;
  assign w_work_nxt = {w_bcd_adj, w_shift[BIN_W-1:0]};
  assign w_last     = (r_cnt == CW'(BIN_W - 1));

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nib (w_shift[BIN_W + 4*g +: 4]),
      .o_nib (w_bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_work[BIN_W + 4*i +: 4] > BCD_MAX_DIGIT) w_bad = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = w_bad ? DONE : SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    if (r_done_ph) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_cnt     <= '0;
      r_done_ph <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_bin     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work    <= {bcd_in, {BIN_W{1'b0}}};
            r_cnt     <= '0;
            r_done_ph <= 1'b0;
          end
        end
        CHECK: begin
          if (w_bad) begin
            r_err <= 1'b1;
            r_bin <= '0;
          end else begin
            r_err <= 1'b0;
          end
        end
        SHIFT: begin
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_bin <= w_work_nxt[BIN_W-1:0];
        end
        DONE: begin
          r_done_ph <= 1'b1;
          r_valid   <= ~r_done_ph;
        end
        default: ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign valid   = r_valid;
  assign bin_out = r_bin;
  assign err     = r_err;

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Directed bench for bcd_bin_seq: vector table, overlap/reset corner cases and a full sweep.
module tb_bcd_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        valid;
  logic [9:0]  bin_out;
  logic        err;

  int n_chk;
  int n_fail;

  bcd_bin_seq #(.N_DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .valid   (valid),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        e;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic run_conv(input logic [11:0] v, output logic [9:0] b, output logic e,
                          output int lat);
    int n;
    n = 0;
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 12'h888;
    chk("busy_after_start", busy, 1);
    while (!valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n + 1;
    b   = bin_out;
    e   = err;
    @(posedge clk);
    #1;
    chk("valid_one_cycle", valid, 0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [9:0] b;
    logic       e;
    int         lat;
    int         pulses;
    int         idx;
    int         last;
    int         cyc;
    logic [9:0] got_bin;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 12'h000;

    vecs[0] = '{12'h000, 10'd0,   1'b0, 13};
    vecs[1] = '{12'h999, 10'd999, 1'b0, 13};
    vecs[2] = '{12'h255, 10'd255, 1'b0, 13};
    vecs[3] = '{12'h1A3, 10'd0,   1'b1, 3};
    vecs[4] = '{12'h010, 10'd10,  1'b0, 13};
    vecs[5] = '{12'h0F0, 10'd0,   1'b1, 3};
    vecs[6] = '{12'h900, 10'd900, 1'b0, 13};
    vecs[7] = '{12'h09A, 10'd0,   1'b1, 3};
    vecs[8] = '{12'h001, 10'd1,   1'b0, 13};
    vecs[9] = '{12'h508, 10'd508, 1'b0, 13};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  busy,    0);
    chk("rst_valid", valid,   0);
    chk("rst_err",   err,     0);
    chk("rst_bin",   bin_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bcd, b, e, lat);
      chk($sformatf("vec%0d_bin", i), b,   vecs[i].bin);
      chk($sformatf("vec%0d_err", i), e,   vecs[i].e);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // held result while idle
    repeat (4) @(posedge clk);
    #1;
    chk("hold_bin", bin_out, 508);
    chk("hold_err", err,     0);

    // second start while busy is ignored, and bcd_in changes are not picked up
    pulses  = 0;
    got_bin = '0;
    @(negedge clk);
    bcd_in = 12'h123;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        bcd_in = 12'h456;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (valid) begin
        pulses++;
        got_bin = bin_out;
      end
    end
    start = 1'b0;
    chk("overlap_pulses", pulses,  1);
    chk("overlap_bin",    got_bin, 123);

    // reset mid-conversion aborts with no valid pulse
    pulses = 0;
    @(negedge clk);
    bcd_in = 12'h777;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      rst_n = !(c == 6 || c == 7);
      @(posedge clk);
      #1;
      if (valid) pulses++;
      if (c == 6) begin
        chk("abort_busy", busy,    0);
        chk("abort_bin",  bin_out, 0);
        chk("abort_err",  err,     0);
      end
    end
    rst_n = 1'b1;
    chk("abort_pulses", pulses, 0);
    run_conv(12'h777, b, e, lat);
    chk("post_rst_bin", b,   777);
    chk("post_rst_err", e,   0);
    chk("post_rst_lat", lat, 13);

    // full sweep with start held high: back-to-back conversions
    @(negedge clk);
    bcd_in = to_bcd(0);
    start  = 1'b1;
    idx  = 0;
    last = 0;
    cyc  = 0;
    while (idx < 1000 && cyc < 16000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid) begin
        chk("sweep_bin", bin_out, idx);
        chk("sweep_err", err, 0);
        if (idx > 0) chk("sweep_spacing", cyc - last, 14);
        last = cyc;
        idx++;
        bcd_in = to_bcd(idx < 1000 ? idx : 0);
        if (idx == 1000) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("sweep_count", idx, 1000);

    repeat (4) @(posedge clk);
    #1;
    chk("final_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_bin_seq.md
BCD_BIN_SEQ -- requirements
Module: bcd_bin_seq

Interface
REQ-001 Parameter N_DIGITS, default 3; number of packed BCD input digits.
REQ-002 Parameter BIN_W, default 10; binary result width, which must hold 10^N_DIGITS - 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  request a conversion; sampled only in IDLE.
REQ-006 bcd_in  input  4*N_DIGITS  packed BCD operand, most significant digit in the top nibble.
REQ-007 busy  output  1  high while a conversion is in progress (CHECK, SHIFT and DONE states).
REQ-008 valid  output  1  one-cycle pulse; bin_out and err are final when this is high.
REQ-009 bin_out  output  BIN_W  binary result; held until the next accepted start.
REQ-010 err  output  1  set when any input digit is greater than 9; held with bin_out.

Function
REQ-011 The FSM SHALL have four states: IDLE, CHECK, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL capture bcd_in into a working register, clear the iteration counter, go to CHECK and raise busy on the next cycle.
REQ-013 In IDLE with start=0, the block SHALL stay in IDLE and leave bin_out and err unchanged.
REQ-014 CHECK SHALL last one cycle and handle digit validity as follows:
- any captured digit > 9: set err=1, set bin_out=0, go to DONE;
- otherwise: clear err and go to SHIFT.
REQ-015 The working register SHALL be {bcd_part[4*N_DIGITS-1:0], bin_part[BIN_W-1:0]}, with bin_part cleared on capture.
REQ-016 Each SHIFT cycle SHALL perform one reverse double-dabble step:
- logical right shift of the whole working register by 1;
- then every bcd_part nibble >= 8 is reduced by 3.
REQ-017 SHIFT SHALL run exactly BIN_W cycles, counted by a counter of width clog2(BIN_W+1), and then go to DONE.
REQ-018 On entry to DONE, bin_out SHALL be loaded from bin_part; DONE SHALL assert valid for exactly one cycle and then return to IDLE.
REQ-019 Latency SHALL be fixed:
- valid conversion: start sampled at edge k gives valid=1 in the cycle after edge k+BIN_W+2, which is 13 cycles for the defaults;
- error case: valid=1 after edge k+2.
REQ-020 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-021 A start held high through DONE SHALL be accepted on the first IDLE cycle, giving back-to-back conversions with one idle cycle between them.
REQ-022 bcd_in SHALL be ignored after capture; changes during busy do not affect the result.
REQ-023 For inputs 0 to 10^N_DIGITS - 1, bin_out SHALL equal the decimal value of bcd_in exactly; no overflow is possible.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL go to IDLE with busy=0, valid=0, err=0, bin_out=0, and with the counter and working register cleared.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no valid pulse; the first start after rst_n=1 SHALL convert normally.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Structure
REQ-027 A shared package bcd_pkg SHALL hold:
- the state encoding (IDLE=2'd0, CHECK=2'd1, SHIFT=2'd2, DONE=2'd3);
- the constants N_DIGITS_DEF=3, BIN_W_DEF=10 and BCD_MAX_DIGIT=9.
REQ-028 One combinational sub-module, bcd_digit_adj, SHALL take a 4-bit nibble and output nibble-3 when the nibble is >= 8, otherwise the nibble unchanged.
REQ-029 bcd_digit_adj SHALL be instantiated N_DIGITS times in a generate loop.
REQ-030 The RTL SHALL contain no division, modulo or multiplication operators.

Verification
REQ-031 Reset, then start with bcd_in=12'h000 -> valid after 13 cycles with bin_out=10'd0 and err=0.
REQ-032 bcd_in=12'h999 -> bin_out=10'd999 (10'h3E7), err=0; bcd_in=12'h255 -> bin_out=10'd255 (10'h0FF).
REQ-033 bcd_in=12'h1A3 -> valid after 3 cycles with err=1 and bin_out=0; then bcd_in=12'h010 -> err=0 and bin_out=10'd10.
REQ-034 Start with 12'h123, then pulse start with 12'h456 at cycle 5 -> exactly one valid pulse, with bin_out=10'd123.
REQ-035 Start with 12'h777, then drive rst_n=0 at cycle 6 -> no valid pulse, outputs 0; after release, 12'h777 -> bin_out=10'd777.
REQ-036 Sweep all 1000 legal codes 000 to 999 with start held high -> every valid pulse matches a reference model, with no err pulse and a constant 14-cycle spacing.
